// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter
//
// Arbitrates up to NUM_REQ register-file write requesters onto two write
// ports (A and B) each cycle. It uses round-robin order starting at rr_ptr.
//   - Slot A goes to the first valid requester in the scan.
//   - Slot B goes to the next valid requester whose address differs from
//     slot A's address, so the two ports never write the same register.
// Grants (req_ready_o) are combinational. The write ports are registered,
// so a grant in cycle t appears on the write port in cycle t+1.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   stall_i           suppresses all grants while high
//   req_valid_i       per-requester write request
//   req_addr_i        per-requester target address (packed, one per requester)
//   req_data_i        per-requester write data (packed, one per requester)
//   req_ready_o       per-requester grant (at most two bits set)
//   waddr_a_o, wdata_a_o, we_a_o   register-file write port A
//   waddr_b_o, wdata_b_o, we_b_o   register-file write port B
module rf_wport_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                stall_i,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    output logic [ADDR_WIDTH-1:0]               waddr_a_o,
    output logic [DATA_WIDTH-1:0]               wdata_a_o,
    output logic                                we_a_o,
    output logic [ADDR_WIDTH-1:0]               waddr_b_o,
    output logic [DATA_WIDTH-1:0]               wdata_b_o,
    output logic                                we_b_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_ptr_next;
    logic [PTR_W-1:0] idx_a;
    logic [PTR_W-1:0] idx_b;
    logic [PTR_W-1:0] cur;
    logic [PTR_W-1:0] last;
    logic             found_a;
    logic             found_b;
    logic             grant_a;
    logic             grant_b;
    int               pos;

    // Circular scan from rr_ptr. A requester that collides with slot A's
    // address is skipped, and a later requester with a distinct address
    // may still take slot B.
    always_comb begin
        found_a = 1'b0;
        found_b = 1'b0;
        idx_a   = '0;
        idx_b   = '0;
        cur     = '0;
        pos     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cur = PTR_W'(pos);
            if (req_valid_i[cur]) begin
                if (!found_a) begin
                    found_a = 1'b1;
                    idx_a   = cur;
                end else if (!found_b && (req_addr_i[cur] != req_addr_i[idx_a])) begin
                    found_b = 1'b1;
                    idx_b   = cur;
                end
            end
        end
    end

    // Grants are gated by stall and reset. The pointer advances past the
    // last requester granted; slot B is always later in scan order than A.
    always_comb begin
        grant_a     = found_a && !stall_i && !rst;
        grant_b     = found_b && !stall_i && !rst;
        last        = grant_b ? idx_b : idx_a;
        rr_ptr_next = (last == PTR_W'(NUM_REQ - 1)) ? '0 : last + 1'b1;
        req_ready_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((grant_a && (idx_a == PTR_W'(i))) || (grant_b && (idx_b == PTR_W'(i)))) begin
                req_ready_o[i] = 1'b1;
            end
        end
    end

    // Write ports capture the granted request one cycle later. Address and
    // data hold their last value when the enable drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            we_a_o    <= 1'b0;
            we_b_o    <= 1'b0;
            waddr_a_o <= '0;
            waddr_b_o <= '0;
            wdata_a_o <= '0;
            wdata_b_o <= '0;
        end else begin
            we_a_o <= grant_a;
            we_b_o <= grant_b;
            if (grant_a) begin
                waddr_a_o <= req_addr_i[idx_a];
                wdata_a_o <= req_data_i[idx_a];
                rr_ptr    <= rr_ptr_next;
            end
            if (grant_b) begin
                waddr_b_o <= req_addr_i[idx_b];
                wdata_b_o <= req_data_i[idx_b];
            end
        end
    end

endmodule

// File: doc/rf_wport_arbiter.md
RF_WPORT_ARBITER -- requirements
Module: rf_wport_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of write requesters (2..8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, giving the register-file address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, giving the register-file data width.
REQ-004 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port stall_i  input  1  when high, no grants are issued.
REQ-007 The block SHALL have port req_valid_i  input  NUM_REQ  per-requester write request.
REQ-008 The block SHALL have port req_addr_i  input  NUM_REQ x ADDR_WIDTH  per-requester target address.
REQ-009 The block SHALL have port req_data_i  input  NUM_REQ x DATA_WIDTH  per-requester write data.
REQ-010 The block SHALL have port req_ready_o  output  NUM_REQ  per-requester grant; the handshake completes when valid and ready are both high.
REQ-011 The block SHALL have ports waddr_a_o / wdata_a_o / we_a_o  output  ADDR_WIDTH / DATA_WIDTH / 1  register-file write port A.
REQ-012 The block SHALL have ports waddr_b_o / wdata_b_o / we_b_o  output  ADDR_WIDTH / DATA_WIDTH / 1  register-file write port B.

Function
REQ-013 The block SHALL keep a round-robin pointer rr_ptr of width clog2(NUM_REQ), with range 0..NUM_REQ-1.
REQ-014 Each cycle, the block SHALL scan requesters in circular order rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
REQ-015 The first valid requester found in the scan SHALL get slot A.
REQ-016 The next valid requester whose address differs from slot A's address SHALL get slot B.
REQ-017 A requester skipped because its address equals slot A's address SHALL not be granted that cycle.
REQ-018 req_ready_o SHALL be combinational and asserted only for the requesters holding slot A or slot B; at most 2 bits SHALL be set at once.
REQ-019 req_ready_o[i] SHALL never be high while req_valid_i[i] is low.
REQ-020 When stall_i=1 or rst=1, req_ready_o SHALL be all zeros.
REQ-021 The write-port outputs SHALL be registered, with one cycle of latency: a slot-A grant in cycle t drives we_a_o=1 and the granted addr/data in cycle t+1; slot B drives port B the same way.
REQ-022 we_a_o and we_b_o SHALL be 0 in any cycle that follows a cycle without the corresponding grant; waddr/wdata SHALL hold their previous values when the enable is 0.
REQ-023 we_a_o and we_b_o SHALL never both be 1 with waddr_a_o equal to waddr_b_o.
REQ-024 If any grant occurs, rr_ptr SHALL become (index of the last granted requester + 1) mod NUM_REQ; otherwise rr_ptr SHALL hold.
REQ-025 A requester that keeps valid asserted SHALL be granted within NUM_REQ cycles in which stall_i=0.
REQ-026 A requester SHALL hold addr/data stable while valid and not ready; the block does not check this.
REQ-027 If only one requester is valid, it SHALL get slot A and port B SHALL stay idle.

Reset
REQ-028 When rst is sampled high, the block SHALL set rr_ptr=0, we_a_o=0, we_b_o=0, waddr_a_o=waddr_b_o=0 and wdata_a_o=wdata_b_o=0 on the next edge.
REQ-029 Reset asserted mid-operation SHALL discard any grant in that cycle; no write SHALL appear on the following cycle.
REQ-030 In the first cycle after rst deasserts, arbitration SHALL start from requester 0.

Verification
REQ-031 Bench scenario, simultaneous requests: after reset, all 4 valid with addrs 1,2,3,4 -> cycle 0 grants req0 (A) and req1 (B); cycle 1 port A addr 1 and port B addr 2, then req2/req3 are granted; rr_ptr returns to 0.
REQ-032 Bench scenario, address conflict: req0 and req1 both target addr 7 with data 0xAA/0xBB -> only req0 is granted; next cycle port A writes 0xAA and we_b_o=0; req1 is granted the following cycle and writes 0xBB.
REQ-033 Bench scenario, stall: stall_i=1 for 3 cycles with req2 valid -> ready stays 0 and no we; once stall_i drops, req2 is granted the same cycle.
REQ-034 Bench scenario, fairness: req0 continuously valid with req3 valid and rr_ptr=3 -> req3 gets slot A and req0 gets slot B in the same cycle.
REQ-035 Bench scenario, reset mid-grant: rst=1 in a cycle where req1 is valid -> req_ready_o=0, next cycle we_a_o=we_b_o=0, rr_ptr=0.
REQ-036 The bench SHALL check REQ-018, REQ-019 and REQ-023 as assertions throughout random traffic with NUM_REQ=4 and NUM_REQ=3.
